ysyx_25040101_regfile_sb: RTL and testbench

YSYX_25040101_REGFILE_SB -- requirements
Module: ysyx_25040101_regfile_sb

---
 rtl/ysyx_25040101_regfile_sb_if.sv | 36 +++
 rtl/ysyx_25040101_regfile_sb.sv | 117 +++++++++++
 tb/tb_ysyx_25040101_regfile_sb.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040101_regfile_sb_if.sv
// Register-file / scoreboard bundle: read ports, write ports, destination
// reservation handshake, flush and the flat debug image.
//   slave  : the register file (drives rs_data_o, rs_busy_o, alloc_ready_o, regs_data_o)
//   master : the pipeline side (drives addresses, writes, alloc and flush)
interface ysyx_25040101_regfile_sb_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRP  = 2,
  parameter int unsigned NWP  = 2
) ();
  localparam int unsigned AW = $clog2(NREG);

  logic [NRP*AW-1:0]    rs_addr_i;
  logic [NRP*XLEN-1:0]  rs_data_o;
  logic [NRP-1:0]       rs_busy_o;
  logic [NWP-1:0]       wr_en_i;
  logic [NWP*AW-1:0]    wr_addr_i;
  logic [NWP*XLEN-1:0]  wr_data_i;
  logic                 alloc_valid_i;
  logic [AW-1:0]        alloc_addr_i;
  logic                 alloc_ready_o;
  logic                 flush_i;
  logic [NREG*XLEN-1:0] regs_data_o;

  modport slave (
    input  rs_addr_i, wr_en_i, wr_addr_i, wr_data_i,
           alloc_valid_i, alloc_addr_i, flush_i,
    output rs_data_o, rs_busy_o, alloc_ready_o, regs_data_o
  );

  modport master (
    output rs_addr_i, wr_en_i, wr_addr_i, wr_data_i,
           alloc_valid_i, alloc_addr_i, flush_i,
    input  rs_data_o, rs_busy_o, alloc_ready_o, regs_data_o
  );
endinterface

// File: rtl/ysyx_25040101_regfile_sb.sv
// Multi-port register file with a per-register pending-write scoreboard.
//   clk  : sole clock, state updates on rising edge
//   rst  : asynchronous active-high reset (registers and pending bits to 0)
//   bus  : slave side of ysyx_25040101_regfile_sb_if
//          reads are combinational with optional same-cycle write forwarding;
//          x0 reads 0, is never written and never marked pending.
module ysyx_25040101_regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NRP    = 2,
  parameter int unsigned NWP    = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_25040101_regfile_sb_if.slave bus
);
  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0]     regs_q [NREG];
  logic [XLEN-1:0]     regs_d [NREG];
  logic [NREG-1:0]     pend_q;
  logic [NREG-1:0]     pend_d;

  logic [AW-1:0]       w_addr [NWP];
  logic [XLEN-1:0]     w_data [NWP];
  logic [NWP-1:0]      w_en;
  logic                alloc_wr_hit;
  logic                alloc_ok;

  logic [AW-1:0]       rd_addr [NRP];
  logic [NRP*XLEN-1:0] rd_data_flat;
  logic [NRP-1:0]      rd_busy;
  logic [NREG*XLEN-1:0] regs_flat;

  // Unpack write ports; writes to x0 are treated as not enabled.
  always_comb begin
    for (int unsigned p = 0; p < NWP; p++) begin
      w_addr[p] = bus.wr_addr_i[p*AW +: AW];
      w_data[p] = bus.wr_data_i[p*XLEN +: XLEN];
      w_en[p]   = bus.wr_en_i[p] && (w_addr[p] != '0);
    end
  end

  // Reservation accept: a same-cycle write to the target retires the old owner.
  always_comb begin
    alloc_wr_hit = 1'b0;
    for (int unsigned p = 0; p < NWP; p++) begin
      if (w_en[p] && (w_addr[p] == bus.alloc_addr_i)) alloc_wr_hit = 1'b1;
    end
    alloc_ok = bus.alloc_valid_i && !bus.flush_i &&
               ((bus.alloc_addr_i == '0) || !pend_q[bus.alloc_addr_i] || alloc_wr_hit);
  end

  // Next state: later write ports override earlier ones; alloc beats write-clear; flush beats all.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int unsigned p = 0; p < NWP; p++) begin
      if (w_en[p]) begin
        regs_d[w_addr[p]] = w_data[p];
        pend_d[w_addr[p]] = 1'b0;
      end
    end
    if (alloc_ok && (bus.alloc_addr_i != '0)) pend_d[bus.alloc_addr_i] = 1'b1;
    if (bus.flush_i) pend_d = '0;
    regs_d[0] = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  // Read ports; forwarding is suppressed during reset so outputs stay zero.
  always_comb begin
    rd_data_flat = '0;
    rd_busy      = '0;
    for (int unsigned k = 0; k < NRP; k++) begin
      rd_addr[k]                   = bus.rs_addr_i[k*AW +: AW];
      rd_data_flat[k*XLEN +: XLEN] = regs_q[rd_addr[k]];
      rd_busy[k]                   = pend_q[rd_addr[k]];
      if ((BYPASS != 0) && !rst) begin
        for (int unsigned p = 0; p < NWP; p++) begin
          if (w_en[p] && (w_addr[p] == rd_addr[k])) begin
            rd_data_flat[k*XLEN +: XLEN] = w_data[p];
            rd_busy[k]                   = 1'b0;
          end
        end
      end
      if (rd_addr[k] == '0) begin
        rd_data_flat[k*XLEN +: XLEN] = '0;
        rd_busy[k]                   = 1'b0;
      end
    end
  end

  // Flat debug image; slot 0 is held at zero by the next-state logic.
  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      regs_flat[i*XLEN +: XLEN] = regs_q[i];
    end
  end

  assign bus.rs_data_o     = rd_data_flat;
  assign bus.rs_busy_o     = rd_busy;
  assign bus.alloc_ready_o = alloc_ok;
  assign bus.regs_data_o   = regs_flat;

endmodule

// File: tb/tb_ysyx_25040101_regfile_sb.sv
// Directed bench: stimulus pushes hand-computed expectations tagged with the
// cycle they apply to; a monitor at the falling edge pops and compares them.
module tb_ysyx_25040101_regfile_sb;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned NRP  = 2;
  localparam int unsigned NWP  = 2;
  localparam int unsigned AW   = 5;

  localparam int K_RSD  = 0;
  localparam int K_BSY  = 1;
  localparam int K_ARDY = 2;
  localparam int K_REG  = 3;

  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  string kname [4] = '{"rs_data", "rs_busy", "alloc_ready", "regs_data"};

  ysyx_25040101_regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) bus ();

  ysyx_25040101_regfile_sb #(
    .XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP), .BYPASS(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic clear_inputs();
    bus.rs_addr_i     = '0;
    bus.wr_en_i       = '0;
    bus.wr_addr_i     = '0;
    bus.wr_data_i     = '0;
    bus.alloc_valid_i = 1'b0;
    bus.alloc_addr_i  = '0;
    bus.flush_i       = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic rd(input int k, input int a);
    bus.rs_addr_i[k*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    bus.wr_en_i[p]              = 1'b1;
    bus.wr_addr_i[p*AW +: AW]   = AW'(a);
    bus.wr_data_i[p*XLEN +: XLEN] = d;
  endtask

  task automatic al(input int a);
    bus.alloc_valid_i = 1'b1;
    bus.alloc_addr_i  = AW'(a);
  endtask

  task automatic ex(input int kind, input int idx, input logic [31:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.idx  = idx;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] actual(input int kind, input int idx);
    case (kind)
      K_RSD:   return bus.rs_data_o[idx*XLEN +: XLEN];
      K_BSY:   return {31'b0, bus.rs_busy_o[idx]};
      K_ARDY:  return {31'b0, bus.alloc_ready_o};
      default: return bus.regs_data_o[idx*XLEN +: XLEN];
    endcase
  endfunction

  // Monitor: compare every expectation belonging to the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        exp_t e;
        logic [31:0] a;
        e = exp_q.pop_front();
        a = actual(e.kind, e.idx);
        checks++;
        if (e.cyc != cyc || a !== e.val) begin
          errors++;
          $display("FAIL %s[%0d] cyc %0d: got %h, expected %h (tagged cyc %0d)",
                   kname[e.kind], e.idx, cyc, a, e.val, e.cyc);
        end
      end
    end
  end

  initial begin
    clear_inputs();

    // Inputs during reset: write/alloc discarded, forwarding suppressed.
    step(); al(3); wr(0, 5, 32'hAAAA5555); rd(0, 5);
    ex(K_RSD, 0, 0); ex(K_BSY, 0, 0); ex(K_ARDY, 0, 1); ex(K_REG, 5, 0);
    step(); rst = 1'b0; rd(0, 3); rd(1, 5);
    ex(K_BSY, 0, 0); ex(K_RSD, 1, 0);

    // Basic write then read.
    step(); wr(0, 5, 32'hDEADBEEF);
    step(); rd(1, 5); ex(K_RSD, 1, 32'hDEADBEEF); ex(K_REG, 5, 32'hDEADBEEF);

    // Dual write same address: highest port wins for bypass and commit.
    step(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(0, 7); rd(1, 5);
    ex(K_RSD, 0, 32'h22); ex(K_RSD, 1, 32'hDEADBEEF);
    step(); rd(0, 7); ex(K_RSD, 0, 32'h22); ex(K_REG, 7, 32'h22);

    // x0 is immutable and never pending.
    step(); wr(0, 0, 32'hFFFFFFFF); al(0); rd(0, 0); rd(1, 0);
    ex(K_RSD, 0, 0); ex(K_RSD, 1, 0); ex(K_ARDY, 0, 1); ex(K_BSY, 0, 0);
    step(); rd(0, 5); ex(K_REG, 0, 0); ex(K_RSD, 0, 32'hDEADBEEF); ex(K_ARDY, 0, 0);

    // Reservation, WAW stall, write clears busy, alloc beats write-clear.
    step(); al(3); rd(0, 3); ex(K_ARDY, 0, 1); ex(K_BSY, 0, 0);
    step(); al(3); rd(0, 3); ex(K_BSY, 0, 1); ex(K_ARDY, 0, 0); ex(K_RSD, 0, 0);
    step(); wr(1, 3, 32'h5); al(3); rd(0, 3);
    ex(K_BSY, 0, 0); ex(K_RSD, 0, 32'h5); ex(K_ARDY, 0, 1);
    step(); rd(0, 3); ex(K_BSY, 0, 1); ex(K_RSD, 0, 32'h5);
    step(); wr(0, 3, 32'h9); rd(1, 3); ex(K_RSD, 1, 32'h9); ex(K_BSY, 1, 0);
    step(); rd(1, 3); ex(K_BSY, 1, 0); ex(K_RSD, 1, 32'h9);

    // Flush clears reservations, blocks alloc, still commits writes.
    step(); al(9); ex(K_ARDY, 0, 1);
    step(); al(10); rd(0, 9); ex(K_ARDY, 0, 1); ex(K_BSY, 0, 1);
    step(); bus.flush_i = 1'b1; wr(0, 11, 32'h7); al(12); rd(0, 9); rd(1, 10);
    ex(K_ARDY, 0, 0); ex(K_BSY, 0, 1); ex(K_BSY, 1, 1);
    step(); rd(0, 9); rd(1, 10); ex(K_BSY, 0, 0); ex(K_BSY, 1, 0); ex(K_REG, 11, 32'h7);
    step(); rd(0, 12); rd(1, 11); ex(K_BSY, 0, 0); ex(K_RSD, 1, 32'h7);

    // Asynchronous reset mid-operation with a write and alloc in flight.
    step(); al(3); ex(K_ARDY, 0, 1);
    step(); rst = 1'b1; wr(0, 4, 32'h1234); al(4); rd(0, 3); rd(1, 4);
    ex(K_RSD, 0, 0); ex(K_RSD, 1, 0); ex(K_BSY, 0, 0); ex(K_REG, 5, 0); ex(K_ARDY, 0, 1);
    step(); rst = 1'b0; rd(0, 4); rd(1, 3);
    ex(K_RSD, 0, 0); ex(K_BSY, 1, 0); ex(K_REG, 4, 0);
    step(); rd(0, 4); ex(K_BSY, 0, 0); ex(K_REG, 5, 0);

    // Drain the scoreboard with a bounded wait.
    begin
      int budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
